// File: rtl/debug_apb_arbiter.sv
// Two-requester APB master: round-robin arbitration over a REQ/ACK handshake,
// legal SETUP/ACCESS sequencing, and a bounded PREADY wait.
// Ports:
//   PCLK, PRESETn           clock, synchronous active-low reset
//   Rn_REQ/ADDR/WRITE/WDATA requester n transfer request and payload
//   Rn_ACK/RDATA/ERR        requester n completion pulse, read data, timeout flag
//   PSEL/PENABLE/PWRITE     APB master controls
//   PADDR/PWDATA/PRDATA     APB address, write data, read data
//   PREADY                  APB ready
//   BUSY                    transfer in flight (SETUP, ACCESS, DONE)
//   GRANT                   requester owning the current or last transfer
module debug_apb_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       R0_REQ,
  input  logic [7:0] R0_ADDR,
  input  logic       R0_WRITE,
  input  logic [7:0] R0_WDATA,
  output logic       R0_ACK,
  output logic [7:0] R0_RDATA,
  output logic       R0_ERR,
  input  logic       R1_REQ,
  input  logic [7:0] R1_ADDR,
  input  logic       R1_WRITE,
  input  logic [7:0] R1_WDATA,
  output logic       R1_ACK,
  output logic [7:0] R1_RDATA,
  output logic       R1_ERR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  output logic       BUSY,
  output logic       GRANT
);

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            grant_q, grant_d;
  logic [DW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic            pwrite_q, pwrite_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;
  logic [1:0]      ack_q, ack_d;
  logic [1:0]      err_q, err_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            busy_q, busy_d;

  logic            win_c;
  logic            xfer_end_c;
  logic            timeout_c;
  logic [DW-1:0]   rd_val_c;

  // Next-state, arbitration and completion logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    grant_d    = grant_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    ack_d      = 2'b00;
    err_d      = 2'b00;
    win_c      = 1'b0;
    xfer_end_c = 1'b0;
    timeout_c  = 1'b0;
    rd_val_c   = PRDATA;

    case (state_q)
      S_IDLE: begin
        if (R0_REQ || R1_REQ) begin
          // On a tie the requester that did not own the last transfer wins
          win_c    = (R0_REQ && R1_REQ) ? ~last_q : R1_REQ;
          grant_d  = win_c;
          last_d   = win_c;
          paddr_d  = win_c ? R1_ADDR  : R0_ADDR;
          pwrite_d = win_c ? R1_WRITE : R0_WRITE;
          pwdata_d = win_c ? R1_WDATA : R0_WDATA;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        // cnt_q counts ACCESS cycles already spent; PREADY beats the timeout
        if (PREADY) begin
          xfer_end_c = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          xfer_end_c = 1'b1;
          timeout_c  = 1'b1;
        end
        if (xfer_end_c) begin
          state_d         = S_DONE;
          ack_d[grant_q]  = 1'b1;
          err_d[grant_q]  = timeout_c;
          rd_val_c        = timeout_c ? '0 : PRDATA;
          if (!pwrite_q) begin
            if (grant_q) rdata1_d = rd_val_c;
            else         rdata0_d = rd_val_c;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d = (state_d == S_ACCESS);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      ack_q     <= 2'b00;
      err_q     <= 2'b00;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      busy_q    <= busy_d;
    end
  end

  assign R0_ACK   = ack_q[0];
  assign R1_ACK   = ack_q[1];
  assign R0_ERR   = err_q[0];
  assign R1_ERR   = err_q[1];
  assign R0_RDATA = rdata0_q;
  assign R1_RDATA = rdata1_q;
  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = pwrite_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign BUSY     = busy_q;
  assign GRANT    = grant_q;

endmodule

// File: tb/tb_debug_apb_arbiter.sv
// Bench for debug_apb_arbiter: directed requests, an APB slave model with a
// programmable ready cycle, and a scoreboard checked on each ACK pulse.
module tb_debug_apb_arbiter;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       R0_REQ, R0_WRITE, R1_REQ, R1_WRITE;
  logic [7:0] R0_ADDR, R0_WDATA, R1_ADDR, R1_WDATA;
  logic       R0_ACK, R0_ERR, R1_ACK, R1_ERR;
  logic [7:0] R0_RDATA, R1_RDATA;
  logic       PSEL, PENABLE, PWRITE, PREADY, BUSY, GRANT;
  logic [7:0] PADDR, PWDATA, PRDATA;

  debug_apb_arbiter #(.TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .R0_REQ(R0_REQ), .R0_ADDR(R0_ADDR), .R0_WRITE(R0_WRITE), .R0_WDATA(R0_WDATA),
    .R0_ACK(R0_ACK), .R0_RDATA(R0_RDATA), .R0_ERR(R0_ERR),
    .R1_REQ(R1_REQ), .R1_ADDR(R1_ADDR), .R1_WRITE(R1_WRITE), .R1_WDATA(R1_WDATA),
    .R1_ACK(R1_ACK), .R1_RDATA(R1_RDATA), .R1_ERR(R1_ERR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .BUSY(BUSY), .GRANT(GRANT)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic       g;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       wr;
    logic       err;
    int         ncyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ready_at = 0;   // ACCESS cycle on which the slave raises PREADY; 0 = never
  int   acc_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic g, input logic [7:0] addr, input logic [7:0] wdata,
                      input logic [7:0] rdata, input logic wr, input logic err, input int ncyc);
    exp_t e;
    e.g = g; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    e.wr = wr; e.err = err; e.ncyc = ncyc;
    sb.push_back(e);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, {23'd0, PSEL, PENABLE, PWRITE, BUSY, GRANT, R0_ACK, R1_ACK, R0_ERR, R1_ERR}, 32'd0);
    chk({tag, "_paddr"}, {24'd0, PADDR}, 32'd0);
    chk({tag, "_pwdata"}, {24'd0, PWDATA}, 32'd0);
    chk({tag, "_r0_rdata"}, {24'd0, R0_RDATA}, 32'd0);
    chk({tag, "_r1_rdata"}, {24'd0, R1_RDATA}, 32'd0);
  endtask

  // Wait for n ACK pulses; without hold each requester drops REQ on its own ACK
  task automatic run(input int n, input bit hold);
    int got = 0;
    int budget = 0;
    while (got < n && budget < 300) begin
      @(negedge PCLK);
      budget++;
      if (R0_ACK === 1'b1 || R1_ACK === 1'b1) begin
        got++;
        if (!hold) begin
          if (R0_ACK === 1'b1) R0_REQ = 1'b0;
          if (R1_ACK === 1'b1) R1_REQ = 1'b0;
        end
      end
    end
    R0_REQ = hold ? 1'b0 : R0_REQ;
    R1_REQ = hold ? 1'b0 : R1_REQ;
    if (got < n) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_wait: got %0d acks want %0d", got, n);
    end
  endtask

  // APB slave: PREADY on the programmed ACCESS cycle
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) acc_n = acc_n + 1;
    else                 acc_n = 0;
    PREADY = PSEL && PENABLE && (acc_n == ready_at);
  end

  // Monitor: ACCESS length, idle gap between transfers, scoreboard on ACK
  int  acc_m = 0;
  int  low_run = 0;
  bit  seen = 1'b0;
  logic pen_prev = 1'b0;
  always @(negedge PCLK) begin
    exp_t e;
    if (PSEL && !PENABLE) acc_m = 0;
    else if (PENABLE)     acc_m++;
    if (PENABLE && !pen_prev && seen) chk("penable_gap", 32'(low_run >= 2), 32'd1);
    if (PENABLE) begin
      low_run = 0;
      seen = 1'b1;
    end else begin
      low_run++;
    end
    pen_prev = PENABLE;
    if (R0_ACK === 1'b1 || R1_ACK === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: r0=%0b r1=%0b want none", R0_ACK, R1_ACK);
      end else begin
        e = sb.pop_front();
        chk("ack_r0", 32'(R0_ACK), 32'(!e.g));
        chk("ack_r1", 32'(R1_ACK), 32'(e.g));
        chk("grant", 32'(GRANT), 32'(e.g));
        chk("paddr", 32'(PADDR), 32'(e.addr));
        chk("pwrite", 32'(PWRITE), 32'(e.wr));
        chk("pwdata", 32'(PWDATA), 32'(e.wdata));
        chk("rdata", 32'(e.g ? R1_RDATA : R0_RDATA), 32'(e.rdata));
        chk("err", 32'(e.g ? R1_ERR : R0_ERR), 32'(e.err));
        chk("err_other", 32'(e.g ? R0_ERR : R1_ERR), 32'd0);
        chk("access_cycles", 32'(acc_m), 32'(e.ncyc));
      end
    end
  end

  initial begin
    int w;
    PRESETn = 1'b0;
    R0_REQ = 1'b0; R0_ADDR = 8'h00; R0_WRITE = 1'b0; R0_WDATA = 8'h00;
    R1_REQ = 1'b0; R1_ADDR = 8'h00; R1_WRITE = 1'b0; R1_WDATA = 8'h00;
    PRDATA = 8'h00;
    PREADY = 1'b0;
    repeat (3) @(negedge PCLK);
    chk_reset("reset");
    PRESETn = 1'b1;

    // Tie, round-robin: both held, R0 first after reset
    @(negedge PCLK);
    ready_at = 1;
    R0_ADDR = 8'h30; R0_WRITE = 1'b1; R0_WDATA = 8'h11;
    R1_ADDR = 8'h31; R1_WRITE = 1'b1; R1_WDATA = 8'h22;
    push(1'b0, 8'h30, 8'h11, 8'h00, 1'b1, 1'b0, 1);
    push(1'b1, 8'h31, 8'h22, 8'h00, 1'b1, 1'b0, 1);
    push(1'b0, 8'h30, 8'h11, 8'h00, 1'b1, 1'b0, 1);
    push(1'b1, 8'h31, 8'h22, 8'h00, 1'b1, 1'b0, 1);
    R0_REQ = 1'b1; R1_REQ = 1'b1;
    run(4, 1'b1);

    // Single read with PREADY on the 2nd ACCESS cycle, cycle-exact latency
    @(negedge PCLK);
    ready_at = 2; PRDATA = 8'h5C;
    R0_ADDR = 8'h0A; R0_WRITE = 1'b0; R0_WDATA = 8'h00;
    push(1'b0, 8'h0A, 8'h00, 8'h5C, 1'b0, 1'b0, 2);
    R0_REQ = 1'b1;
    @(negedge PCLK);
    chk("c1_setup", {30'd0, PSEL, PENABLE}, 32'b10);
    @(negedge PCLK);
    chk("c2_access", {30'd0, PSEL, PENABLE}, 32'b11);
    @(negedge PCLK);
    chk("c3_access", {30'd0, PSEL, PENABLE}, 32'b11);
    @(negedge PCLK);
    chk("c4_ack", {30'd0, R0_ACK, BUSY}, 32'b11);
    R0_REQ = 1'b0;

    // Write preserves earlier read data
    @(negedge PCLK);
    ready_at = 1; PRDATA = 8'h3C;
    R0_ADDR = 8'h20; R0_WRITE = 1'b0; R0_WDATA = 8'h00;
    push(1'b0, 8'h20, 8'h00, 8'h3C, 1'b0, 1'b0, 1);
    R0_REQ = 1'b1;
    run(1, 1'b0);
    PRDATA = 8'h77;
    R0_ADDR = 8'h21; R0_WRITE = 1'b1; R0_WDATA = 8'hFF;
    push(1'b0, 8'h21, 8'hFF, 8'h3C, 1'b1, 1'b0, 1);
    R0_REQ = 1'b1;
    run(1, 1'b0);
    @(negedge PCLK);
    chk("r0_rdata_kept", 32'(R0_RDATA), 32'h3C);

    // PREADY on the last allowed ACCESS cycle wins over timeout
    ready_at = 4; PRDATA = 8'hA5;
    R1_ADDR = 8'h40; R1_WRITE = 1'b0; R1_WDATA = 8'h00;
    push(1'b1, 8'h40, 8'h00, 8'hA5, 1'b0, 1'b0, 4);
    R1_REQ = 1'b1;
    run(1, 1'b0);

    // Timeout: no PREADY, 4 ACCESS cycles, ERR with zeroed read data
    ready_at = 0; PRDATA = 8'hEE;
    R1_ADDR = 8'h50;
    push(1'b1, 8'h50, 8'h00, 8'h00, 1'b0, 1'b1, 4);
    R1_REQ = 1'b1;
    run(1, 1'b0);
    @(negedge PCLK);
    chk("idle_after_timeout", {30'd0, BUSY, PSEL}, 32'd0);

    // Reset in ACCESS aborts without ACK; R0 then wins the tie
    R0_ADDR = 8'h60; R0_WRITE = 1'b0; R0_WDATA = 8'h00;
    R0_REQ = 1'b1;
    w = 0;
    while (PENABLE !== 1'b1 && w < 20) begin
      @(negedge PCLK);
      w++;
    end
    chk("reached_access", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    R1_ADDR = 8'h61; R1_WRITE = 1'b0; R1_WDATA = 8'h00;
    R1_REQ = 1'b1;
    @(negedge PCLK);
    chk_reset("mid_reset");
    ready_at = 1; PRDATA = 8'h99;
    push(1'b0, 8'h60, 8'h00, 8'h99, 1'b0, 1'b0, 1);
    push(1'b1, 8'h61, 8'h00, 8'h99, 1'b0, 1'b0, 1);
    PRESETn = 1'b1;
    run(2, 1'b0);

    repeat (3) @(negedge PCLK);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
